// File: rtl/fetch_stage_pkg.sv
// Shared constants and fetch-action decode for the MIPS instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned CNT_W          = 32;
  localparam int unsigned PC_INCR        = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    ActHold     = 2'd0,
    ActRedirect = 2'd1,
    ActBubble   = 2'd2,
    ActAdvance  = 2'd3
  } fetchAction_t;

  // Priority: stall, then any redirect (jump over branch), then memory wait, then advance.
  function automatic fetchAction_t decodeAction(input logic stall, input logic jump,
                                                input logic branch, input logic ready);
    fetchAction_t act;
    if (stall)               act = ActHold;
    else if (jump || branch) act = ActRedirect;
    else if (!ready)         act = ActBubble;
    else                     act = ActAdvance;
    return act;
  endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating event counter with enable and asynchronous active-low reset.
module sat_counter
  import fetch_stage_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  output logic [W-1:0] Count
);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Count <= '0;
    end else if (En && (Count != '1)) begin
      Count <= Count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register of the five-stage MIPS datapath.
// Performance counters are built only when FETCH_PERF_COUNTERS_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned        DATA_W   = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0]  RESET_PC = DATA_W'(DEFAULT_RESET_PC)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              StallIn,
  input  logic              BranchTaken,
  input  logic [DATA_W-1:0] BranchTarget,
  input  logic              JumpTaken,
  input  logic [DATA_W-1:0] JumpTarget,
  input  logic              IMemReady,
  input  logic [DATA_W-1:0] IMemData,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IFID_Instruction,
  output logic [DATA_W-1:0] IFID_PCPlus4,
  output logic              IFID_Valid,
  output logic [31:0]       StallCount,
  output logic [31:0]       FlushCount
);

  fetchAction_t      action;
  logic [DATA_W-1:0] pcPlus4;
  logic [DATA_W-1:0] redirectTarget;
  logic [DATA_W-1:0] pcNext;
  logic [DATA_W-1:0] instrNext;
  logic [DATA_W-1:0] pcPlus4Next;
  logic              validNext;

  assign action         = decodeAction(StallIn, JumpTaken, BranchTaken, IMemReady);
  assign pcPlus4        = PC + DATA_W'(PC_INCR);
  // Jump wins over a simultaneous branch; targets are forced word-aligned.
  assign redirectTarget = JumpTaken ? {JumpTarget[DATA_W-1:2], 2'b00}
                                    : {BranchTarget[DATA_W-1:2], 2'b00};

  // Next-state selection for PC and IF/ID
  always_comb begin
    pcNext      = PC;
    instrNext   = IFID_Instruction;
    pcPlus4Next = IFID_PCPlus4;
    validNext   = IFID_Valid;
    case (action)
      ActHold: begin
      end
      ActRedirect: begin
        pcNext      = redirectTarget;
        instrNext   = DATA_W'(NOP_INSTR);
        pcPlus4Next = '0;
        validNext   = 1'b0;
      end
      ActBubble: begin
        instrNext   = DATA_W'(NOP_INSTR);
        pcPlus4Next = '0;
        validNext   = 1'b0;
      end
      ActAdvance: begin
        pcNext      = pcPlus4;
        instrNext   = IMemData;
        pcPlus4Next = pcPlus4;
        validNext   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      PC               <= RESET_PC;
      IFID_Instruction <= DATA_W'(NOP_INSTR);
      IFID_PCPlus4     <= '0;
      IFID_Valid       <= 1'b0;
    end else begin
      PC               <= pcNext;
      IFID_Instruction <= instrNext;
      IFID_PCPlus4     <= pcPlus4Next;
      IFID_Valid       <= validNext;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic redirectAccepted;

  assign redirectAccepted = (action == ActRedirect);

  sat_counter #(.W(32)) stallCounter (
    .Clk   (Clk),
    .Rst   (Rst),
    .En    (StallIn),
    .Count (StallCount)
  );

  sat_counter #(.W(32)) flushCounter (
    .Clk   (Clk),
    .Rst   (Rst),
    .En    (redirectAccepted),
    .Count (FlushCount)
  );
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule
